fetch_stage: RTL and testbench

- Pipelined instruction-fetch front end for the five-stage MIPS core.
- Owns the fetch PC and drives a latency-tolerant instruction-memory port.
- Buffers fetched words in a small FIFO and presents {pc, instr} to the decode stage with a valid/ready handshake.
- Decode/execute drive `redirect` for branches, jumps, `jal` and `jr`; fetch flushes and refetches from the new target.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // One buffered fetch result as seen by decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch entries with flush; head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; flush discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Present the oldest entry, or all-zero when nothing is buffered.
  always_comb begin
    head = '0;
    if (count != '0) begin
      head = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues single outstanding
// memory requests, buffers results and hands {pc, instr} to decode.
// Optional build macro FETCH_ADEL_EN: misaligned fetch PCs produce an
// address-error entry instead of a memory request, then fetch stalls until redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_exc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q;
  logic          out_q;
  logic          drop_q;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          pop;
  logic          resp_push;
  logic          adel_push;
  logic          push;
  logic          can_issue;
  logic          issue;
`ifdef FETCH_ADEL_EN
  logic          stall_q;
`endif

  // Handshake, issue and push decisions for the current cycle.
  always_comb begin
    pop       = (count != '0) && id_ready && !redirect_valid;
    resp_push = imem_rvalid && out_q && !drop_q && !redirect_valid;
    can_issue = !redirect_valid && (!out_q || imem_rvalid) &&
                ((32'(count) + 32'(out_q)) < (DEPTH + 32'(pop)));
`ifdef FETCH_ADEL_EN
    issue     = can_issue && !stall_q && (pc_q[1:0] == 2'b00);
    adel_push = can_issue && !stall_q && (pc_q[1:0] != 2'b00) && !resp_push;
`else
    issue     = can_issue;
    adel_push = 1'b0;
`endif
    push = resp_push || adel_push;
    // pc_q already advanced past the outstanding request, so its address is one step back.
    if (resp_push) begin
      push_data = '{pc: pc_q - PC_STEP, instr: imem_rdata, exc: 1'b0};
    end else begin
      push_data = '{pc: pc_q, instr: NOP_INSTR, exc: 1'b1};
    end
  end

  // Fetch PC, outstanding-request and drop-next-response tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      out_q  <= 1'b0;
      drop_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_pc;
      out_q  <= out_q && !imem_rvalid;
      drop_q <= out_q && !imem_rvalid;
    end else begin
      if (issue) begin
        pc_q  <= pc_q + PC_STEP;
        out_q <= 1'b1;
      end else if (imem_rvalid) begin
        out_q <= 1'b0;
      end
      if (imem_rvalid) begin
        drop_q <= 1'b0;
      end
    end
  end

`ifdef FETCH_ADEL_EN
  // Hold fetch after an address error until decode redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 1'b0;
    end else if (redirect_valid) begin
      stall_q <= 1'b0;
    end else if (adel_push) begin
      stall_q <= 1'b1;
    end
  end
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .count (count)
  );

  // Memory request port and decode-facing outputs.
  always_comb begin
    imem_req  = issue && reset;
    imem_addr = pc_q;
    id_valid  = (count != '0);
    id_pc     = head.pc;
    id_instr  = head.instr;
    id_exc    = head.exc;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model plus scoreboard of expected decode entries.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_exc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_3000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_exc         (id_exc)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
    int          gen;
  } rsp_t;

  rsp_t         pend[$];
  fetch_entry_t sb[$];

  int          n_run = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          gen = 0;
  int          lat = 1;
  logic [31:0] exp_req_pc = 32'h0000_3000;
  logic        rst_drv = 1'b0;
  logic        ready_drv = 1'b1;
  logic        redir_now = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic        stray_now = 1'b0;
  logic        mem_hold = 1'b0;
  logic        adel_seen = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample #1 later.
  task automatic tick();
    rsp_t r;
    logic rv;
    logic [31:0] rd;
    @(negedge clk);
    cyc++;
    rv = 1'b0;
    rd = '0;
    if (stray_now) begin
      rv = 1'b1;
      rd = 32'hDEAD_BEEF;
      stray_now = 1'b0;
    end else if (!mem_hold && pend.size() > 0 && pend[0].due <= cyc) begin
      r  = pend.pop_front();
      rv = 1'b1;
      rd = mem_word(r.addr);
      if (r.gen == gen && !redir_now && rst_drv)
        sb.push_back('{pc: r.addr, instr: mem_word(r.addr), exc: 1'b0});
    end
    reset          = rst_drv;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    id_ready       = ready_drv;
    redirect_valid = redir_now;
    redirect_pc    = redir_now ? redir_tgt : '0;
    #1;
    if (reset) begin
      if (id_valid && id_ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out", id_valid, 1'b0);
        end else begin
          fetch_entry_t e;
          e = sb.pop_front();
          check("id_pc", id_pc, e.pc);
          check("id_instr", id_instr, e.instr);
          check("id_exc", id_exc, e.exc);
          if (e.exc && id_exc && id_pc == e.pc) adel_seen = 1'b1;
        end
      end
`ifdef FETCH_ADEL_EN
      if (exp_req_pc[1:0] != 2'b00) check("adel_no_req", imem_req, 1'b0); else
`endif
      if (imem_req) begin
        check("req_addr", imem_addr, exp_req_pc);
        pend.push_back('{due: cyc + lat, addr: exp_req_pc, gen: gen});
        exp_req_pc += 32'd4;
      end
    end
    if (redir_now) begin
      sb.delete();
      gen++;
      exp_req_pc = redir_tgt;
`ifdef FETCH_ADEL_EN
      if (redir_tgt[1:0] != 2'b00)
        sb.push_back('{pc: redir_tgt, instr: 32'h0, exc: 1'b1});
`endif
      redir_now = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1'b0;
    gen++;
    sb.delete();
    exp_req_pc = 32'h0000_3000;
    repeat (n) begin
      tick();
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_id_valid", id_valid, 1'b0);
      check("rst_id_pc", id_pc, 32'h0);
      check("rst_id_instr", id_instr, 32'h0);
      check("rst_id_exc", id_exc, 1'b0);
    end
    pend.delete();
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redir_now = 1'b1;
    redir_tgt = tgt;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;

    do_reset(3);

    // Streaming after reset release: back-to-back requests, id_valid from cycle 2.
    rst_drv = 1'b1;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 3) check("t1_req_b2b", imem_req, 1'b1);
      check("t1_id_valid", id_valid, (i >= 2));
    end

    // Decode stalled: FIFO fills, no requests, head holds.
    ready_drv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_no_req", imem_req, 1'b0);
      check("t2_valid", id_valid, 1'b1);
      if (sb.size() > 0) check("t2_head_pc", id_pc, sb[0].pc);
    end
    ready_drv = 1'b1;
    run(10);

    // Slow memory; redirect while a request is outstanding with no response this cycle.
    lat = 3;
    run(8);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due > cyc + 1) found = 1'b1;
      else tick();
    end
    check("t3_found_window", found, 1'b1);
    redirect_to(32'h0000_3100);
    tick();
    check("t3_flushed", id_valid, 1'b0);
    run(20);

    // Redirect coinciding with a response and a would-be pop.
    lat = 1;
    run(6);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due == cyc + 1 && id_valid) found = 1'b1;
      else tick();
    end
    check("t4_found_window", found, 1'b1);
    redirect_to(32'h0000_3200);
    check("t4_no_req", imem_req, 1'b0);
    tick();
    check("t4_empty", id_valid, 1'b0);
    check("t4_req", imem_req, 1'b1);
    run(10);

    // Reset mid-stream with a request outstanding, then a stray response.
    lat = 3;
    run(5);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (pend.size() > 0) found = 1'b1;
      else tick();
    end
    check("t5_outstanding", found, 1'b1);
    do_reset(2);
    stray_now = 1'b1;
    rst_drv = 1'b1;
    tick();
    check("t5_req_after_rel", imem_req, 1'b1);
    run(15);

`ifdef FETCH_ADEL_EN
    // Misaligned redirect produces an address-error entry and stalls fetch.
    lat = 1;
    run(4);
    redirect_to(32'h0000_3102);
    run(6);
    check("t6_adel_seen", adel_seen, 1'b1);
    redirect_to(32'h0000_3000);
    tick();
    check("t6_resume_req", imem_req, 1'b1);
    run(10);
`endif

    // Stop memory responses and let decode drain everything buffered.
    lat = 1;
    run(5);
    mem_hold = 1'b1;
    run(6);
    check("sb_drain", sb.size(), 32'd0);
    check("end_id_valid", id_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
